// File: rtl/memory_access_unit.sv
// EX/MEM data-memory access stage: issues one load/store at a time, waits for
// dmem_ack with a timeout, and presents a registered MEM/WB slot.
module memory_access_unit #(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        valid_in,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [2:0]  funct3,
  input  logic [31:0] address,
  input  logic [31:0] store_data,
  input  logic [4:0]  rd_in,
  input  logic        reg_write_in,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  output logic [3:0]  dmem_be,
  input  logic        dmem_ack,
  input  logic [31:0] dmem_rdata,
  output logic        stall,
  output logic        valid_out,
  output logic        reg_write_out,
  output logic [4:0]  rd_out,
  output logic [31:0] result,
  output logic        fault,
  output logic [1:0]  fault_cause
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [31:0]   addr_q, addr_d;
  logic [1:0]    off_q, off_d;
  logic [3:0]    be_q, be_d;
  logic [31:0]   wdata_q, wdata_d;
  logic          we_q, we_d;
  logic [2:0]    f3_q, f3_d;
  logic          acc_rw_q, acc_rw_d;
  logic          valid_q, valid_d;
  logic          fault_q, fault_d;
  logic [1:0]    cause_q, cause_d;
  logic          rw_q, rw_d;
  logic [4:0]    rd_q, rd_d;
  logic [31:0]   result_q, result_d;

  logic        access, bad_f3, misaligned, busy, accept;
  logic [3:0]  be_calc;
  logic [31:0] wdata_calc, rshift, load_val;

  assign access     = valid_in & (mem_read | mem_write);
  assign bad_f3     = (funct3 == 3'b011) | (funct3[2:1] == 2'b11);
  assign misaligned = ((funct3[1:0] == 2'b10) & (address[1:0] != 2'b00)) |
                      ((funct3[1:0] == 2'b01) & address[0]);
  assign busy       = (state_q == BUSY);
  assign accept     = (state_q == IDLE) & access & ~bad_f3 & ~misaligned;

  always_comb begin
    be_calc    = 4'b1111;
    wdata_calc = store_data;
    case (funct3[1:0])
      2'b00: begin
        be_calc    = 4'b0001 << address[1:0];
        wdata_calc = {4{store_data[7:0]}};
      end
      2'b01: begin
        be_calc    = 4'b0011 << address[1:0];
        wdata_calc = {2{store_data[15:0]}};
      end
      default: ;
    endcase
  end

  // Bring the addressed lane down to bit 0, then extend per the latched funct3.
  assign rshift = dmem_rdata >> {off_q, 3'b000};
  always_comb begin
    load_val = dmem_rdata;
    case (f3_q)
      3'b000:  load_val = {{24{rshift[7]}}, rshift[7:0]};
      3'b001:  load_val = {{16{rshift[15]}}, rshift[15:0]};
      3'b100:  load_val = {24'b0, rshift[7:0]};
      3'b101:  load_val = {16'b0, rshift[15:0]};
      default: load_val = dmem_rdata;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    addr_d   = addr_q;
    off_d    = off_q;
    be_d     = be_q;
    wdata_d  = wdata_q;
    we_d     = we_q;
    f3_d     = f3_q;
    acc_rw_d = acc_rw_q;
    valid_d  = 1'b0;
    fault_d  = 1'b0;
    rw_d     = 1'b0;
    cause_d  = cause_q;
    rd_d     = rd_q;
    result_d = result_q;
    case (state_q)
      IDLE: begin
        if (valid_in) begin
          rd_d = rd_in;
          if (!access) begin
            valid_d  = 1'b1;
            rw_d     = reg_write_in;
            result_d = address;
            cause_d  = 2'b00;
          end else if (bad_f3) begin
            valid_d = 1'b1;
            fault_d = 1'b1;
            cause_d = 2'b10;
          end else if (misaligned) begin
            valid_d = 1'b1;
            fault_d = 1'b1;
            cause_d = 2'b01;
          end else begin
            state_d  = BUSY;
            cnt_d    = '0;
            addr_d   = {address[31:2], 2'b00};
            off_d    = address[1:0];
            be_d     = be_calc;
            wdata_d  = wdata_calc;
            we_d     = mem_write;
            f3_d     = funct3;
            acc_rw_d = reg_write_in & ~mem_write;
          end
        end
      end
      BUSY: begin
        if (dmem_ack) begin
          state_d = DONE;
          valid_d = 1'b1;
          rw_d    = acc_rw_q;
          cause_d = 2'b00;
          if (!we_q) result_d = load_val;
        end else if (cnt_q == CNT_LAST) begin
          state_d = DONE;
          valid_d = 1'b1;
          fault_d = 1'b1;
          cause_d = 2'b11;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      addr_q   <= '0;
      off_q    <= '0;
      be_q     <= '0;
      wdata_q  <= '0;
      we_q     <= 1'b0;
      f3_q     <= '0;
      acc_rw_q <= 1'b0;
      valid_q  <= 1'b0;
      fault_q  <= 1'b0;
      cause_q  <= '0;
      rw_q     <= 1'b0;
      rd_q     <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      addr_q   <= addr_d;
      off_q    <= off_d;
      be_q     <= be_d;
      wdata_q  <= wdata_d;
      we_q     <= we_d;
      f3_q     <= f3_d;
      acc_rw_q <= acc_rw_d;
      valid_q  <= valid_d;
      fault_q  <= fault_d;
      cause_q  <= cause_d;
      rw_q     <= rw_d;
      rd_q     <= rd_d;
      result_q <= result_d;
    end
  end

  assign dmem_req      = busy;
  assign dmem_we       = busy & we_q;
  assign dmem_addr     = busy ? addr_q : '0;
  assign dmem_wdata    = busy ? wdata_q : '0;
  assign dmem_be       = busy ? be_q : '0;
  assign stall         = ~rst & (busy | (valid_in & accept));
  assign valid_out     = valid_q;
  assign fault         = fault_q;
  assign fault_cause   = cause_q;
  assign reg_write_out = rw_q;
  assign rd_out        = rd_q;
  assign result        = result_q;

endmodule

// File: tb/tb_memory_access_unit.sv
// Bench for memory_access_unit: directed vector table, hand sequences for
// reset/ack corner cases, and random instructions against a reference model.
module tb_memory_access_unit;

  localparam int T = 4;

  logic        clk = 1'b0;
  logic        rst, valid_in, mem_read, mem_write, reg_write_in, dmem_ack;
  logic [2:0]  funct3;
  logic [31:0] address, store_data, dmem_rdata;
  logic [4:0]  rd_in;
  logic        dmem_req, dmem_we, stall, valid_out, reg_write_out, fault;
  logic [31:0] dmem_addr, dmem_wdata, result;
  logic [3:0]  dmem_be;
  logic [4:0]  rd_out;
  logic [1:0]  fault_cause;

  int tests = 0;
  int fails = 0;
  int vo_cnt = 0;

  always #5 clk = ~clk;

  memory_access_unit #(.TIMEOUT_CYCLES(T)) dut (
    .clk(clk), .rst(rst), .valid_in(valid_in), .mem_read(mem_read),
    .mem_write(mem_write), .funct3(funct3), .address(address),
    .store_data(store_data), .rd_in(rd_in), .reg_write_in(reg_write_in),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_wdata(dmem_wdata), .dmem_be(dmem_be), .dmem_ack(dmem_ack),
    .dmem_rdata(dmem_rdata), .stall(stall), .valid_out(valid_out),
    .reg_write_out(reg_write_out), .rd_out(rd_out), .result(result),
    .fault(fault), .fault_cause(fault_cause)
  );

  always @(negedge clk) if (valid_out === 1'b1) vo_cnt++;

  typedef struct {
    logic [2:0]  f3;
    bit          ld;
    bit          st;
    logic [31:0] addr;
    logic [31:0] sdata;
    logic [4:0]  rdi;
    bit          rwi;
    logic [31:0] rdata;
    int          delay;
    bit          exp_req;
    int          exp_busy;
    logic [3:0]  exp_be;
    logic [31:0] exp_wdata;
    logic [31:0] exp_result;
    bit          exp_fault;
    logic [1:0]  exp_cause;
    bit          exp_rw;
    bit          chk_res;
  } vec_t;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic vec_t mk(logic [2:0] f3, bit ld, bit st, logic [31:0] addr,
      logic [31:0] sdata, logic [4:0] rdi, bit rwi, logic [31:0] rdata, int delay,
      bit req, int busy, logic [3:0] be, logic [31:0] wdata, logic [31:0] res,
      bit flt, logic [1:0] cause, bit rw, bit chkres);
    vec_t v;
    v.f3 = f3; v.ld = ld; v.st = st; v.addr = addr; v.sdata = sdata;
    v.rdi = rdi; v.rwi = rwi; v.rdata = rdata; v.delay = delay;
    v.exp_req = req; v.exp_busy = busy; v.exp_be = be; v.exp_wdata = wdata;
    v.exp_result = res; v.exp_fault = flt; v.exp_cause = cause;
    v.exp_rw = rw; v.chk_res = chkres;
    return v;
  endfunction

  // Reference model: outcome of one instruction from the access rules alone.
  function automatic vec_t model(input vec_t v);
    vec_t e = v;
    int n, off;
    logic [31:0] mask, val;
    e.exp_req = 0; e.exp_busy = 0; e.exp_be = 0; e.exp_wdata = 0;
    e.exp_result = 0; e.exp_fault = 0; e.exp_cause = 0; e.exp_rw = v.rwi;
    e.chk_res = 0;
    if (!(v.ld || v.st)) begin
      e.exp_result = v.addr;
      e.chk_res = 1;
      return e;
    end
    e.exp_rw = 0;
    if (v.f3 == 3 || v.f3 == 6 || v.f3 == 7) begin
      e.exp_fault = 1; e.exp_cause = 2'b10;
      return e;
    end
    n = (v.f3 % 4 == 0) ? 1 : (v.f3 % 4 == 1) ? 2 : 4;
    off = int'(v.addr % 4);
    if (off % n != 0) begin
      e.exp_fault = 1; e.exp_cause = 2'b01;
      return e;
    end
    e.exp_req = 1;
    e.exp_busy = (v.delay < T) ? v.delay + 1 : T;
    e.exp_be = 4'(((1 << n) - 1) << off);
    for (int i = 0; i < 4; i++) e.exp_wdata[8*i +: 8] = v.sdata[8*(i % n) +: 8];
    if (v.delay >= T) begin
      e.exp_fault = 1; e.exp_cause = 2'b11;
      return e;
    end
    if (!v.st) begin
      mask = (n == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8*n)) - 1);
      val = (v.rdata / (32'd1 << (8*off))) & mask;
      if (v.f3 < 4 && n < 4 && val >= (32'd1 << (8*n - 1))) val = val | ~mask;
      e.exp_result = val;
      e.exp_rw = v.rwi;
      e.chk_res = 1;
    end
    return e;
  endfunction

  // Entry and exit: 1 time unit after a rising edge.
  task automatic run_instr(input vec_t v);
    logic [31:0] exp_addr;
    exp_addr = v.addr - (v.addr % 4);
    valid_in = 1; mem_read = v.ld; mem_write = v.st; funct3 = v.f3;
    address = v.addr; store_data = v.sdata; rd_in = v.rdi;
    reg_write_in = v.rwi; dmem_rdata = v.rdata; dmem_ack = 1;
    @(negedge clk);
    chk("issue_stall", stall, v.exp_req);
    chk("issue_req", dmem_req, 0);
    @(posedge clk); #1;
    dmem_ack = 0;
    if (v.exp_req) begin
      for (int c = 0; c < v.exp_busy; c++) begin
        chk("busy_valid_out", valid_out, 0);
        dmem_ack = (c == v.delay);
        @(negedge clk);
        chk("busy_req", dmem_req, 1);
        chk("busy_stall", stall, 1);
        chk("busy_we", dmem_we, v.st);
        chk("busy_addr", dmem_addr, exp_addr);
        chk("busy_be", dmem_be, v.exp_be);
        if (v.st) chk("busy_wdata", dmem_wdata, v.exp_wdata);
        @(posedge clk); #1;
      end
      dmem_ack = 0;
    end
    chk("ret_valid_out", valid_out, 1);
    chk("ret_fault", fault, v.exp_fault);
    if (v.exp_fault) chk("ret_cause", fault_cause, v.exp_cause);
    chk("ret_reg_write", reg_write_out, v.exp_rw);
    chk("ret_rd_out", rd_out, v.rdi);
    if (v.chk_res) chk("ret_result", result, v.exp_result);
    chk("ret_req", dmem_req, 0);
    if (v.exp_req) begin
      @(negedge clk);
      chk("done_stall", stall, 0);
      @(posedge clk); #1;
      chk("after_done_valid", valid_out, 0);
    end
  endtask

  task automatic bubble();
    valid_in = 0; mem_read = 0; mem_write = 0; dmem_ack = 0;
    @(negedge clk);
    chk("bubble_stall", stall, 0);
    @(posedge clk); #1;
    chk("bubble_valid", valid_out, 0);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_req"}, dmem_req, 0);
    chk({tag, "_we"}, dmem_we, 0);
    chk({tag, "_be"}, dmem_be, 0);
    chk({tag, "_addr"}, dmem_addr, 0);
    chk({tag, "_wdata"}, dmem_wdata, 0);
    chk({tag, "_stall"}, stall, 0);
    chk({tag, "_valid"}, valid_out, 0);
    chk({tag, "_rw"}, reg_write_out, 0);
    chk({tag, "_rd"}, rd_out, 0);
    chk({tag, "_result"}, result, 0);
    chk({tag, "_fault"}, fault, 0);
    chk({tag, "_cause"}, fault_cause, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl[15];
    vec_t v;
    int base;
    tbl[0]  = mk(3'b000,1,0,32'h103,32'h0,5'd7,1,32'h80AA_BBCC,0, 1,1,4'b1000,32'h0,32'hFFFF_FF80,0,2'b00,1,1);
    tbl[1]  = mk(3'b001,0,1,32'h202,32'h1234_ABCD,5'd3,1,32'h0,1, 1,2,4'b1100,32'hABCD_ABCD,32'h0,0,2'b00,0,0);
    tbl[2]  = mk(3'b010,1,0,32'h101,32'h0,5'd4,1,32'h0,0, 0,0,4'b0,32'h0,32'h0,1,2'b01,0,0);
    tbl[3]  = mk(3'b010,1,0,32'h200,32'h0,5'd9,1,32'h1111_1111,99, 1,4,4'b1111,32'h0,32'h0,1,2'b11,0,0);
    tbl[4]  = mk(3'b000,0,0,32'h1234_5678,32'h0,5'd10,1,32'h0,0, 0,0,4'b0,32'h0,32'h1234_5678,0,2'b00,1,1);
    tbl[5]  = mk(3'b101,1,0,32'h0000_1002,32'h0,5'd11,1,32'h8001_5555,2, 1,3,4'b1100,32'h0,32'h0000_8001,0,2'b00,1,1);
    tbl[6]  = mk(3'b000,0,0,32'hCAFE_F00D,32'h0,5'd12,0,32'h0,0, 0,0,4'b0,32'h0,32'hCAFE_F00D,0,2'b00,0,1);
    tbl[7]  = mk(3'b000,0,1,32'h1,32'h0000_00A5,5'd13,1,32'h0,3, 1,4,4'b0010,32'hA5A5_A5A5,32'h0,0,2'b00,0,0);
    tbl[8]  = mk(3'b011,1,0,32'h40,32'h0,5'd14,1,32'h0,0, 0,0,4'b0,32'h0,32'h0,1,2'b10,0,0);
    tbl[9]  = mk(3'b010,1,1,32'h40,32'hDEAD_BEEF,5'd15,1,32'h5A5A_5A5A,0, 1,1,4'b1111,32'hDEAD_BEEF,32'h0,0,2'b00,0,0);
    tbl[10] = mk(3'b001,1,0,32'h2,32'h0,5'd16,1,32'h8765_4321,1, 1,2,4'b1100,32'h0,32'hFFFF_8765,0,2'b00,1,1);
    tbl[11] = mk(3'b100,1,0,32'h1,32'h0,5'd17,1,32'h0000_F000,0, 1,1,4'b0010,32'h0,32'h0000_00F0,0,2'b00,1,1);
    tbl[12] = mk(3'b001,0,1,32'h203,32'h1,5'd18,0,32'h0,0, 0,0,4'b0,32'h0,32'h0,1,2'b01,0,0);
    tbl[13] = mk(3'b010,1,0,32'h10,32'h0,5'd19,1,32'h0123_4567,0, 1,1,4'b1111,32'h0,32'h0123_4567,0,2'b00,1,1);
    tbl[14] = mk(3'b111,0,1,32'h0,32'h5,5'd20,1,32'h0,0, 0,0,4'b0,32'h0,32'h0,1,2'b10,0,0);

    rst = 1; valid_in = 0; mem_read = 0; mem_write = 0; funct3 = 0;
    address = 0; store_data = 0; rd_in = 0; reg_write_in = 0;
    dmem_ack = 0; dmem_rdata = 0;
    repeat (3) @(posedge clk);
    #1;
    chk_zero("reset");
    rst = 0;
    @(posedge clk); #1;

    base = vo_cnt;
    foreach (tbl[i]) run_instr(tbl[i]);
    bubble();
    chk("table_retire_count", vo_cnt - base, 15);

    // Ack while no request is outstanding.
    dmem_ack = 1;
    @(negedge clk);
    chk("stray_ack_req", dmem_req, 0);
    @(posedge clk); #1;
    chk("stray_ack_valid", valid_out, 0);
    dmem_ack = 0;
    bubble();

    // Reset in the middle of a request, then a late ack.
    valid_in = 1; mem_read = 1; funct3 = 3'b010; address = 32'h300;
    rd_in = 5'd1; reg_write_in = 1;
    @(posedge clk); #1;
    chk("pre_rst_req", dmem_req, 1);
    rst = 1;
    @(posedge clk); #1;
    rst = 0; valid_in = 0; mem_read = 0; dmem_ack = 1;
    dmem_rdata = 32'hFFFF_FFFF;
    @(negedge clk);
    chk_zero("rst_busy");
    @(posedge clk); #1;
    dmem_ack = 0;
    chk("late_ack_valid", valid_out, 0);
    chk("late_ack_req", dmem_req, 0);
    bubble();

    base = vo_cnt;
    for (int i = 0; i < 250; i++) begin
      int k;
      k = int'($urandom_range(0, 9));
      v.f3 = 3'($urandom_range(0, 7));
      v.ld = (k < 5) || (k == 9);
      v.st = (k >= 5);
      v.addr = $urandom;
      v.sdata = $urandom;
      v.rdi = 5'($urandom);
      v.rwi = 1'($urandom);
      v.rdata = $urandom;
      v.delay = int'($urandom_range(0, 5));
      if ($urandom_range(0, 7) == 0) begin v.ld = 0; v.st = 0; end
      v = model(v);
      run_instr(v);
      if ($urandom_range(0, 3) == 0) bubble();
    end
    bubble();
    chk("random_retire_count", vo_cnt - base, 250);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/memory_access_unit.md
MEMORY_ACCESS_UNIT -- requirements
Module: memory_access_unit

Interface
REQ-001 The block SHALL have parameter TIMEOUT_CYCLES, default 16, meaning the maximum number of cycles to wait for dmem_ack before faulting.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state SHALL update on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-004 The block SHALL have port valid_in, input, 1 bit: the EX/MEM slot holds an instruction.
REQ-005 The block SHALL have ports mem_read and mem_write, input, 1 bit each: load request and store request.
REQ-006 The block SHALL have port funct3, input, 3 bits: access size and sign (000 B, 001 H, 010 W, 100 BU, 101 HU).
REQ-007 The block SHALL have port address, input, 32 bits: ALU result, used as the byte address.
REQ-008 The block SHALL have port store_data, input, 32 bits: forwarded rs2 value.
REQ-009 The block SHALL have ports rd_in (input, 5 bits) and reg_write_in (input, 1 bit): destination register and write enable.
REQ-010 The block SHALL have ports dmem_req, dmem_we (output, 1 bit each), dmem_addr, dmem_wdata (output, 32 bits each) and dmem_be (output, 4 bits): the data-memory request.
REQ-011 The block SHALL have ports dmem_ack (input, 1 bit) and dmem_rdata (input, 32 bits): memory completion and read word.
REQ-012 The block SHALL have port stall, output, 1 bit: hold all upstream stages this cycle.
REQ-013 The block SHALL have ports valid_out, reg_write_out (output, 1 bit each), rd_out (output, 5 bits) and result (output, 32 bits): the registered MEM/WB slot.
REQ-014 The block SHALL have ports fault (output, 1 bit) and fault_cause (output, 2 bits): 01 misaligned, 10 illegal funct3, 11 timeout.

Function
REQ-015 The FSM SHALL have three states, IDLE, BUSY and DONE. An access is valid_in AND (mem_read OR mem_write). When both request bits are set, mem_write SHALL take priority.
REQ-016 Non-access behaviour: in IDLE with valid_in set but no access, the next cycle SHALL show valid_out=1, result=address, rd_out=rd_in, reg_write_out=reg_write_in (latency 1).
REQ-017 Fault check: an access SHALL fault when W has address[1:0]!=0, or H/HU has address[0]=1 (cause 01), or funct3 is 011, 110 or 111 (cause 10).
- A faulting access SHALL issue no request.
- The next cycle SHALL show valid_out=1, fault=1, reg_write_out=0.
REQ-018 Accepting an access: a legal access in IDLE SHALL assert stall combinationally, latch the operands and go to BUSY.
REQ-019 Request in BUSY:
- dmem_req=1, dmem_we=store, dmem_addr={addr[31:2],2'b00}.
- All request outputs SHALL stay stable until the dmem_ack cycle.
- stall=1 throughout.
REQ-020 Byte enables and write data:
- B: be=4'b0001<<addr[1:0], wdata=byte replicated 4 times.
- H: be=4'b0011<<addr[1:0], wdata=halfword replicated 2 times.
- W: be=4'b1111, wdata=store_data.
- For loads, be SHALL follow the same size rule.
REQ-021 Completion: dmem_ack in BUSY SHALL end the request and move the FSM to DONE.
- dmem_req SHALL be low the following cycle.
- Loads: result SHALL capture the selected byte/halfword/word of dmem_rdata, sign-extended (B, H) or zero-extended (BU, HU).
- Stores: reg_write_out=0.
REQ-022 DONE SHALL last exactly one cycle with valid_out=1 and stall=0, then return to IDLE; memory-access latency is (ack cycle)+1.
REQ-023 An ack that arrives while dmem_req=0 SHALL be ignored.
REQ-024 Timeout: a cycle counter SHALL run in BUSY and clear on entry.
- If it reaches TIMEOUT_CYCLES without ack: drop dmem_req, go to DONE with fault=1, cause 11, reg_write_out=0.
REQ-025 valid_out, fault and reg_write_out SHALL be 0 in every cycle that does not retire a slot.
REQ-026 stall SHALL never be asserted in DONE, so a new instruction is accepted in the cycle after DONE.

Reset
REQ-027 While rst is high the block SHALL, on the next edge, go to IDLE with counter=0.
- All outputs SHALL be 0: dmem_req, dmem_we, dmem_be, dmem_addr, dmem_wdata, stall, valid_out, reg_write_out, rd_out, result, fault, fault_cause.
REQ-028 Reset asserted in BUSY SHALL abandon the access: dmem_req=0 next cycle, and a late dmem_ack SHALL be ignored.

Verification
REQ-029 LB with address 0x103 and dmem_rdata=0x80AA_BBCC -> dmem_be=4'b1000, result=0xFFFF_FF80, rd_out=rd_in, reg_write_out=1.
REQ-030 SH with address 0x202 and store_data=0x1234_ABCD -> dmem_be=4'b1100, dmem_wdata=0xABCD_ABCD, dmem_we=1, reg_write_out=0.
REQ-031 LW with address 0x101 -> no dmem_req, next cycle fault=1, cause 01, stall never high.
REQ-032 LW with dmem_ack withheld and TIMEOUT_CYCLES=4 -> stall high 5 cycles, then fault=1, cause 11, dmem_req low.
REQ-033 rst during BUSY, then ack on the next cycle -> state IDLE, all outputs 0, no valid_out.
REQ-034 Back-to-back ALU op, LHU (0x8001_xxxx with addr[1]=1) and ALU op -> result=0x0000_8001, with correct stall cycles and no lost or duplicated valid_out.
